// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: request/grant and SDRAM command bus between the arbiter and its clients.
// Ports (slave = arbiter side):
//   in : init_end/init_cmd/init_ba/init_addr, aref_req/aref_end/aref_cmd/aref_ba/aref_addr,
//        wr_req/wr_end/wr_cmd/wr_ba/wr_addr/wr_sdram_en/wr_sdram_data,
//        rd_req/rd_end/rd_cmd/rd_ba/rd_addr
//   out: aref_en, wr_en, rd_en, sdram_cke, sdram_cs_n/ras_n/cas_n/we_n, sdram_ba, sdram_addr, aref_late
interface sdram_arbiter_if;
    logic        init_end;
    logic [3:0]  init_cmd;
    logic [1:0]  init_ba;
    logic [12:0] init_addr;
    logic        aref_req;
    logic        aref_end;
    logic [3:0]  aref_cmd;
    logic [1:0]  aref_ba;
    logic [12:0] aref_addr;
    logic        aref_en;
    logic        wr_req;
    logic        wr_end;
    logic [3:0]  wr_cmd;
    logic [1:0]  wr_ba;
    logic [12:0] wr_addr;
    logic        wr_sdram_en;
    logic [15:0] wr_sdram_data;
    logic        wr_en;
    logic        rd_req;
    logic        rd_end;
    logic [3:0]  rd_cmd;
    logic [1:0]  rd_ba;
    logic [12:0] rd_addr;
    logic        rd_en;
    logic        sdram_cke;
    logic        sdram_cs_n;
    logic        sdram_ras_n;
    logic        sdram_cas_n;
    logic        sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    logic        aref_late;

    modport slave (
        input  init_end, init_cmd, init_ba, init_addr,
        input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_sdram_data,
        input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        output aref_en, wr_en, rd_en,
        output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr,
        output aref_late
    );

    modport master (
        output init_end, init_cmd, init_ba, init_addr,
        output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        output wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_sdram_data,
        output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        input  aref_en, wr_en, rd_en,
        input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr,
        input  aref_late
    );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: fixed-priority (refresh > write > read) owner select for one SDRAM command bus.
// Ports: sys_clk, sys_rst_n (async, active-low); bus (sdram_arbiter_if.slave) carries the
// client requests/commands, grants, muxed SDRAM command/ba/addr, cke and aref_late;
// sdram_dq is the bidirectional data bus, driven only by the write client.
module sdram_arbiter #(
    parameter logic [9:0] AREF_MAX_WAIT = 10'd600
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    sdram_arbiter_if.slave bus,
    inout  wire  [15:0]    sdram_dq
);
    typedef enum logic [2:0] {INIT, ARBIT, AREF, WRITE, READ} state_t;

    state_t      state_q, state_d;
    logic [9:0]  pend_q, pend_d;
    logic        late_q, late_d;
    logic        late_hit;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= INIT;
            pend_q  <= '0;
            late_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            late_q  <= late_d;
        end
    end

    // The flag is visible in the very cycle the wait count reaches the limit.
    assign late_hit = pend_q == AREF_MAX_WAIT;

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    state_d = bus.init_end ? ARBIT : INIT;
            ARBIT:   state_d = bus.aref_req ? AREF : bus.wr_req ? WRITE : bus.rd_req ? READ : ARBIT;
            AREF:    state_d = bus.aref_end ? ARBIT : AREF;
            WRITE:   state_d = bus.wr_end ? ARBIT : WRITE;
            READ:    state_d = bus.rd_end ? ARBIT : READ;
            default: state_d = INIT;
        endcase
        pend_d = (!bus.aref_req || state_q == AREF) ? '0 : (&pend_q ? pend_q : pend_q + 10'd1);
        late_d = late_q | late_hit;
    end

    always_comb begin
        cmd  = 4'b0111;
        ba   = 2'b11;
        addr = 13'h1fff;
        case (state_q)
            INIT:    {cmd, ba, addr} = {bus.init_cmd, bus.init_ba, bus.init_addr};
            AREF:    {cmd, ba, addr} = {bus.aref_cmd, bus.aref_ba, bus.aref_addr};
            WRITE:   {cmd, ba, addr} = {bus.wr_cmd, bus.wr_ba, bus.wr_addr};
            READ:    {cmd, ba, addr} = {bus.rd_cmd, bus.rd_ba, bus.rd_addr};
            default: {cmd, ba, addr} = {4'b0111, 2'b11, 13'h1fff};
        endcase
    end

    assign bus.aref_en = state_q == AREF;
    assign bus.wr_en   = state_q == WRITE;
    assign bus.rd_en   = state_q == READ;
    assign {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} = cmd;
    assign bus.sdram_ba   = ba;
    assign bus.sdram_addr = addr;
    assign bus.sdram_cke  = sys_rst_n;
    assign bus.aref_late  = late_q | late_hit;
    assign sdram_dq = (state_q == WRITE && bus.wr_sdram_en) ? bus.wr_sdram_data : 16'hzzzz;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed scoreboard bench; stimulus queues expected outputs, a negedge monitor checks them.
module tb_sdram_arbiter;
    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    tri1 [15:0] sdram_dq;
    int         total = 0;
    int         bad = 0;

    always #5 sys_clk = ~sys_clk;

    sdram_arbiter_if bus();

    sdram_arbiter #(.AREF_MAX_WAIT(10'd600)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus),
        .sdram_dq  (sdram_dq)
    );

    typedef enum int {S_INIT, S_ARBIT, S_AREF, S_WRITE, S_READ} st_t;

    typedef struct {
        string       tag;
        logic [2:0]  gnt;
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
        logic [15:0] dq;
        logic        late;
        logic        cke;
    } exp_t;

    exp_t q[$];

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic expect_st(input string tag, input st_t st, input logic [15:0] dq, input logic late);
        exp_t e;
        e.tag  = tag;
        e.dq   = dq;
        e.late = late;
        e.cke  = sys_rst_n;
        case (st)
            S_INIT:  begin e.gnt = 3'b000; e.cmd = bus.init_cmd; e.ba = bus.init_ba; e.addr = bus.init_addr; end
            S_AREF:  begin e.gnt = 3'b100; e.cmd = bus.aref_cmd; e.ba = bus.aref_ba; e.addr = bus.aref_addr; end
            S_WRITE: begin e.gnt = 3'b010; e.cmd = bus.wr_cmd;   e.ba = bus.wr_ba;   e.addr = bus.wr_addr;   end
            S_READ:  begin e.gnt = 3'b001; e.cmd = bus.rd_cmd;   e.ba = bus.rd_ba;   e.addr = bus.rd_addr;   end
            default: begin e.gnt = 3'b000; e.cmd = 4'b0111;      e.ba = 2'b11;       e.addr = 13'h1fff;      end
        endcase
        q.push_back(e);
    endtask

    always @(negedge sys_clk) begin
        exp_t        e;
        logic [39:0] got, want;
        if (q.size() != 0) begin
            e = q.pop_front();
            got  = {bus.aref_en, bus.wr_en, bus.rd_en,
                    bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n,
                    bus.sdram_ba, bus.sdram_addr, sdram_dq, bus.aref_late, bus.sdram_cke};
            want = {e.gnt, e.cmd, e.ba, e.addr, e.dq, e.late, e.cke};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL %s: got gnt/cmd/ba/addr/dq/late/cke=%h want %h", e.tag, got, want);
            end
        end
    end

    initial begin
        bus.init_end = 0; bus.init_cmd = 4'b0010; bus.init_ba = 2'b01; bus.init_addr = 13'h0400;
        bus.aref_req = 0; bus.aref_end = 0; bus.aref_cmd = 4'b0010; bus.aref_ba = 2'b10; bus.aref_addr = 13'h0aaa;
        bus.wr_req = 1; bus.wr_end = 0; bus.wr_cmd = 4'b0100; bus.wr_ba = 2'b00; bus.wr_addr = 13'h0123;
        bus.wr_sdram_en = 0; bus.wr_sdram_data = 16'hA5C3;
        bus.rd_req = 0; bus.rd_end = 0; bus.rd_cmd = 4'b0101; bus.rd_ba = 2'b11; bus.rd_addr = 13'h0456;
        expect_st("reset_state", S_INIT, 16'hffff, 0);
        tick; tick;
        sys_rst_n = 1; bus.wr_end = 1;
        expect_st("init_ignores_req", S_INIT, 16'hffff, 0);
        tick; bus.wr_end = 0; bus.init_end = 1;
        expect_st("init_end_seen", S_INIT, 16'hffff, 0);
        tick; bus.init_end = 0; bus.wr_req = 0;
        expect_st("arbit_nop", S_ARBIT, 16'hffff, 0);
        tick; bus.aref_req = 1; bus.wr_req = 1; bus.rd_req = 1;
        expect_st("arbit_all_req", S_ARBIT, 16'hffff, 0);
        tick;
        expect_st("aref_precharge", S_AREF, 16'hffff, 0);
        tick; bus.aref_cmd = 4'b0001; bus.aref_req = 0; bus.wr_end = 1;
        expect_st("aref_refresh_cmd", S_AREF, 16'hffff, 0);
        tick; bus.wr_end = 0; bus.aref_end = 1;
        expect_st("aref_end_pulse", S_AREF, 16'hffff, 0);
        tick; bus.aref_end = 0;
        expect_st("aref_done_nop", S_ARBIT, 16'hffff, 0);
        tick; bus.wr_sdram_en = 1;
        expect_st("wr_grant_dq_drive", S_WRITE, 16'hA5C3, 0);
        tick; bus.wr_sdram_en = 0;
        expect_st("wr_dq_z", S_WRITE, 16'hffff, 0);
        tick; bus.wr_end = 1; bus.wr_req = 0;
        expect_st("wr_end", S_WRITE, 16'hffff, 0);
        tick; bus.wr_end = 0; bus.wr_sdram_en = 1;
        expect_st("arbit_no_dq_drive", S_ARBIT, 16'hffff, 0);
        tick; bus.wr_sdram_en = 0; bus.aref_end = 1;
        expect_st("rd_grant_aref_end_ignored", S_READ, 16'hffff, 0);
        tick; bus.aref_end = 0; bus.rd_req = 0; bus.rd_end = 1;
        expect_st("rd_end", S_READ, 16'hffff, 0);
        tick; bus.rd_end = 0;
        expect_st("rd_done_nop", S_ARBIT, 16'hffff, 0);
        tick; bus.wr_req = 1;
        expect_st("idle_arbit", S_ARBIT, 16'hffff, 0);
        tick; bus.wr_req = 0; bus.wr_end = 1; bus.aref_req = 1;
        expect_st("wr_end_with_aref", S_WRITE, 16'hffff, 0);
        tick; bus.wr_end = 0;
        expect_st("gap_nop_cycle", S_ARBIT, 16'hffff, 0);
        tick; bus.aref_req = 0; bus.aref_end = 1;
        expect_st("aref_after_gap", S_AREF, 16'hffff, 0);
        tick; bus.aref_end = 0; bus.wr_req = 1;
        expect_st("back_to_arbit", S_ARBIT, 16'hffff, 0);
        tick; bus.wr_req = 0; bus.aref_req = 1;
        expect_st("starve_start", S_WRITE, 16'hffff, 0);
        for (int k = 1; k <= 700; k++) begin
            tick;
            if (k == 700) bus.wr_end = 1;
            if (k == 599 || k == 600 || k == 601 || k == 700)
                expect_st($sformatf("late_at_k%0d", k), S_WRITE, 16'hffff, k >= 600);
        end
        tick; bus.wr_end = 0;
        expect_st("late_arbit", S_ARBIT, 16'hffff, 1);
        tick; bus.aref_req = 0; bus.aref_end = 1;
        expect_st("late_aref_served", S_AREF, 16'hffff, 1);
        tick; bus.aref_end = 0; bus.rd_req = 1;
        expect_st("late_sticky", S_ARBIT, 16'hffff, 1);
        tick;
        expect_st("rd_before_reset", S_READ, 16'hffff, 1);
        @(negedge sys_clk); #1;
        sys_rst_n = 0;
        expect_st("reset_mid_read", S_INIT, 16'hffff, 0);
        @(negedge sys_clk);
        tick; sys_rst_n = 1;
        expect_st("post_reset_ignore1", S_INIT, 16'hffff, 0);
        tick;
        expect_st("post_reset_ignore2", S_INIT, 16'hffff, 0);
        tick; bus.init_end = 1;
        expect_st("post_reset_init_end", S_INIT, 16'hffff, 0);
        tick; bus.init_end = 0;
        expect_st("post_reset_arbit", S_ARBIT, 16'hffff, 0);
        tick; bus.rd_req = 0; bus.rd_end = 1;
        expect_st("post_reset_read", S_READ, 16'hffff, 0);
        tick; bus.rd_end = 0;
        expect_st("post_reset_done", S_ARBIT, 16'hffff, 0);
        tick; tick;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter AREF_MAX_WAIT, default 10'd600, meaning maximum cycles aref_req may stay pending before aref_late is flagged.
REQ-002 SHALL have ports: sys_clk in 1 system clock; sys_rst_n in 1 reset, asynchronous, active-low.
REQ-003 SHALL have ports: init_end in 1 init done; init_cmd in 4, init_ba in 2, init_addr in 13, the init command fields.
REQ-004 SHALL have ports: aref_req in 1 refresh request; aref_end in 1 refresh done pulse; aref_cmd in 4, aref_ba in 2, aref_addr in 13; aref_en out 1 refresh grant.
REQ-005 SHALL have ports: wr_req in 1; wr_end in 1; wr_cmd in 4, wr_ba in 2, wr_addr in 13; wr_sdram_en in 1 drive-DQ strobe; wr_sdram_data in 16; wr_en out 1 write grant.
REQ-006 SHALL have ports: rd_req in 1; rd_end in 1; rd_cmd in 4, rd_ba in 2, rd_addr in 13; rd_en out 1 read grant.
REQ-007 SHALL have ports: sdram_cke out 1; sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n out 1 each; sdram_ba out 2; sdram_addr out 13; sdram_dq inout 16; aref_late out 1 sticky starvation flag.

Function
REQ-008 SHALL hold state register with states INIT, ARBIT, AREF, WRITE, READ.
REQ-009 INIT SHALL go to ARBIT on the first cycle init_end=1; otherwise stay in INIT.
REQ-010 ARBIT SHALL select by fixed priority aref_req > wr_req > rd_req, moving to AREF/WRITE/READ on the next edge; no request -> stay in ARBIT.
REQ-011 AREF, WRITE, READ SHALL return to ARBIT on the edge where aref_end, wr_end, rd_end respectively is 1; no pre-emption of an active WRITE/READ by aref_req.
REQ-012 aref_en, wr_en, rd_en SHALL be combinational decodes: 1 exactly while state is AREF, WRITE, READ respectively; at most one asserted at any time.
REQ-013 {sdram_cs_n,sdram_ras_n,sdram_cas_n,sdram_we_n}, sdram_ba, sdram_addr SHALL be a combinational mux: INIT -> init_*; AREF -> aref_*; WRITE -> wr_*; READ -> rd_*; ARBIT -> NOP 4'b0111, ba 2'b11, addr 13'h1fff.
REQ-014 Command encoding SHALL be {cs_n,ras_n,cas_n,we_n}: NOP 0111, PRECHARGE 0010, AUTO REFRESH 0001.
REQ-015 sdram_cke SHALL be 1 whenever sys_rst_n=1.
REQ-016 sdram_dq SHALL be driven with wr_sdram_data only when state=WRITE and wr_sdram_en=1; otherwise high-Z.
REQ-017 Pending counter (10 bits) SHALL clear when aref_req=0 or state=AREF, else increment, saturating at 10'h3ff.
REQ-018 aref_late SHALL set when pending counter equals AREF_MAX_WAIT and stay 1 until reset.
REQ-019 aref_req, wr_req, rd_req same cycle in ARBIT -> AREF only; losers remain pending, no other effect.
REQ-020 wr_end and aref_req same cycle in WRITE -> ARBIT for exactly one cycle (NOP), then AREF.
REQ-021 Requests arriving while in INIT SHALL be ignored until ARBIT; *_end inputs ignored outside the matching state.

Reset
REQ-022 sys_rst_n=0 SHALL asynchronously force state INIT, pending counter 0, aref_late 0, all grants 0, sdram_dq high-Z, sdram_cke 0, mux outputs tracking init_* inputs.
REQ-023 Reset asserted mid-WRITE/READ/AREF SHALL drop the grant and DQ drive in the same cycle, with no completion handshake required.

Verification
REQ-024 Reset, init_end=1 at cycle 10 -> state ARBIT at cycle 11; outputs cmd 0111, ba 11, addr 1fff; no grant.
REQ-025 aref_req, wr_req, rd_req all 1 in ARBIT -> aref_en=1 next cycle, sdram cmd=aref_cmd (0010 then 0001 passed through); aref_end pulse -> ARBIT then wr_en=1 one cycle later.
REQ-026 In WRITE, wr_sdram_en=1, wr_sdram_data=16'hA5C3 -> sdram_dq=A5C3; wr_sdram_en=0 -> sdram_dq=Z; wr_end -> ARBIT.
REQ-027 aref_req raised at WRITE start, wr_end held off 700 cycles with AREF_MAX_WAIT=600 -> aref_late=1 at pending count 600, stays 1 after AREF served.
REQ-028 Reset pulse during READ with rd_en=1 -> rd_en=0 immediately, state INIT, aref_late=0; requests ignored until init_end=1.
REQ-029 rd_req only -> rd_en one cycle later; rd_end -> ARBIT, NOP; aref_end pulses in READ ignored.
